// File: rtl/mm_bus_pkg.sv
// mm_bus_pkg: shared types and default configuration for the memory-map bus
// controller. It holds the controller state encoding, the standard PLP region
// map (bases and decode masks), the default acknowledge timeout, the error
// read pattern and a counter-width helper.
// Optional feature macro used by the controller: MM_BUS_TIMEOUT_EN.

package mm_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mm_state_e;

    localparam int unsigned MM_NREG    = 8;
    localparam int unsigned MM_ADDR_W  = 32;
    localparam int unsigned MM_DATA_W  = 32;
    localparam int unsigned MM_TIMEOUT = 255;

    localparam logic [MM_DATA_W-1:0] MM_ERR_DATA = 32'hdead_beef;

    // Region i sits at [i*ADDR_W +: ADDR_W]:
    // 0 ROM, 1 SRAM, 2 UART, 3 switches, 4 LEDs, 5 VGA, 6 PLPID, 7 timer.
    localparam logic [MM_NREG*MM_ADDR_W-1:0] MM_REGION_BASE = {
        32'hf060_0000, 32'hf050_0000, 32'hf040_0000, 32'hf020_0000,
        32'hf010_0000, 32'hf000_0000, 32'h1000_0000, 32'h0000_0000
    };

    // SRAM decodes a 16 MB window, every other region a 1 MB window.
    localparam logic [MM_NREG*MM_ADDR_W-1:0] MM_REGION_MASK = {
        32'hfff0_0000, 32'hfff0_0000, 32'hfff0_0000, 32'hfff0_0000,
        32'hfff0_0000, 32'hfff0_0000, 32'hff00_0000, 32'hfff0_0000
    };

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 32'd1) ? 32'd1 : $clog2(limit + 32'd1);
    endfunction

endpackage

// File: rtl/mm_bus_ctrl_if.sv
// mm_bus_ctrl_if: CPU data port and memory-mapped module bus as seen by the
// bus controller. The slave modport is the controller's view; the master
// modport is the view of the environment (CPU plus modules).

interface mm_bus_ctrl_if #(
    parameter int unsigned NREG   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    // CPU side
    logic                   cpu_req;
    logic                   cpu_we;
    logic [ADDR_W-1:0]      cpu_addr;
    logic [DATA_W-1:0]      cpu_wdata;
    logic [DATA_W-1:0]      cpu_rdata;
    logic                   cpu_ack;
    logic                   cpu_err;

    // Module side
    logic [NREG-1:0]        mod_sel;
    logic                   mod_we;
    logic [ADDR_W-1:0]      mod_addr;
    logic [DATA_W-1:0]      mod_wdata;
    logic [NREG*DATA_W-1:0] mod_rdata;
    logic [NREG-1:0]        mod_ack;

    // Diagnostics
    logic [ADDR_W-1:0]      err_addr;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mod_rdata, mod_ack,
        output cpu_rdata, cpu_ack, cpu_err,
        output mod_sel, mod_we, mod_addr, mod_wdata, err_addr
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mod_rdata, mod_ack,
        input  cpu_rdata, cpu_ack, cpu_err,
        input  mod_sel, mod_we, mod_addr, mod_wdata, err_addr
    );

endinterface

// File: rtl/mm_region_match.sv
// mm_region_match: combinational priority decoder for the region table.
// Every region is compared in parallel, the lowest matching index wins, and
// the address is returned relative to the winning region.

module mm_region_match
    import mm_bus_pkg::*;
#(
    parameter int unsigned NREG   = MM_NREG,
    parameter int unsigned ADDR_W = MM_ADDR_W,
    parameter logic [NREG*ADDR_W-1:0] BASE = MM_REGION_BASE,
    parameter logic [NREG*ADDR_W-1:0] MASK = MM_REGION_MASK
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NREG-1:0]   sel_o,
    output logic              hit_o,
    output logic [ADDR_W-1:0] eff_addr_o
);

    logic [NREG-1:0]   match_s;
    logic [NREG-1:0]   onehot_s;
    logic [ADDR_W-1:0] eff_s;

    // Raw per-region compare of the masked address against each base.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NREG; i++) begin
            match_s[i] = ((addr_i & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]);
        end
    end

    // Keep only the lowest set bit so overlapping regions resolve to the lower index.
    always_comb begin
        onehot_s = match_s & (~match_s + NREG'(1));
    end

    // Strip the region bits of the winning region; an empty select yields zero.
    always_comb begin
        eff_s = '0;
        for (int i = 0; i < NREG; i++) begin
            eff_s = eff_s | ({ADDR_W{onehot_s[i]}} & addr_i & ~MASK[i*ADDR_W +: ADDR_W]);
        end
    end

    assign sel_o      = onehot_s;
    assign hit_o      = |match_s;
    assign eff_addr_o = eff_s;

endmodule

// File: rtl/mm_bus_ctrl.sv
// mm_bus_ctrl: memory-map bus controller between the CPU data port and the
// memory-mapped modules. A CPU access is decoded against the region table;
// hits drive a one-hot module select until that module acknowledges, misses
// complete at once with an error. Every completion is a single-cycle ack.
// Optional feature macro: MM_BUS_TIMEOUT_EN -- when defined, an access whose
// module does not acknowledge within TIMEOUT cycles completes with an error;
// when undefined the controller waits for the acknowledge indefinitely.

module mm_bus_ctrl
    import mm_bus_pkg::*;
#(
    parameter int unsigned NREG   = MM_NREG,
    parameter int unsigned ADDR_W = MM_ADDR_W,
    parameter int unsigned DATA_W = MM_DATA_W,
    parameter logic [NREG*ADDR_W-1:0] REGION_BASE = MM_REGION_BASE,
    parameter logic [NREG*ADDR_W-1:0] REGION_MASK = MM_REGION_MASK,
    parameter int unsigned TIMEOUT = MM_TIMEOUT,
    parameter logic [DATA_W-1:0] ERR_DATA = MM_ERR_DATA
) (
    input  logic         clk,
    input  logic         rst,
    mm_bus_ctrl_if.slave bus
);

    mm_state_e         state_q;
    logic              cpu_ack_q;
    logic              cpu_err_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [NREG-1:0]   mod_sel_q;
    logic              mod_we_q;
    logic [ADDR_W-1:0] mod_addr_q;
    logic [DATA_W-1:0] mod_wdata_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [NREG-1:0]   dec_sel_s;
    logic              dec_hit_s;
    logic [ADDR_W-1:0] dec_eff_s;
    logic              sel_ack_s;
    logic [DATA_W-1:0] sel_rdata_s;

`ifdef MM_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    logic [CNT_W-1:0]  cnt_q;
    // Full CPU address of the access in flight, reported if it times out.
    logic [ADDR_W-1:0] addr_q;
`else
    // The limit has no effect without the watchdog; this only keeps it referenced.
    logic unused_timeout_s;
    assign unused_timeout_s = |TIMEOUT;
`endif

    mm_region_match #(
        .NREG   (NREG),
        .ADDR_W (ADDR_W),
        .BASE   (REGION_BASE),
        .MASK   (REGION_MASK)
    ) u_match (
        .addr_i     (bus.cpu_addr),
        .sel_o      (dec_sel_s),
        .hit_o      (dec_hit_s),
        .eff_addr_o (dec_eff_s)
    );

    // Only the acknowledge of the currently selected module counts.
    always_comb begin
        sel_ack_s = |(bus.mod_ack & mod_sel_q);
    end

    // One-hot AND-OR mux of the selected module's read data slice.
    always_comb begin
        sel_rdata_s = '0;
        for (int i = 0; i < NREG; i++) begin
            sel_rdata_s = sel_rdata_s | ({DATA_W{mod_sel_q[i]}} & bus.mod_rdata[i*DATA_W +: DATA_W]);
        end
    end

    // Controller FSM: decode in IDLE, hold the module bus through ACCESS, complete in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mod_sel_q   <= '0;
            mod_we_q    <= 1'b0;
            mod_addr_q  <= '0;
            mod_wdata_q <= '0;
            err_addr_q  <= '0;
`ifdef MM_BUS_TIMEOUT_EN
            cnt_q       <= '0;
            addr_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cpu_ack_q <= 1'b0;
                    cpu_err_q <= 1'b0;
                    if (bus.cpu_req) begin
                        if (dec_hit_s) begin
                            state_q     <= ST_ACCESS;
                            mod_sel_q   <= dec_sel_s;
                            mod_we_q    <= bus.cpu_we;
                            mod_addr_q  <= dec_eff_s;
                            mod_wdata_q <= bus.cpu_wdata;
`ifdef MM_BUS_TIMEOUT_EN
                            cnt_q       <= '0;
                            addr_q      <= bus.cpu_addr;
`endif
                        end else begin
                            // Unmapped: nothing to select, answer with an error right away.
                            state_q     <= ST_RESP;
                            cpu_ack_q   <= 1'b1;
                            cpu_err_q   <= 1'b1;
                            cpu_rdata_q <= ERR_DATA;
                            err_addr_q  <= bus.cpu_addr;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_ACCESS: begin
                    if (sel_ack_s) begin
                        // An ack in the expiry cycle still completes normally.
                        state_q     <= ST_RESP;
                        cpu_ack_q   <= 1'b1;
                        cpu_err_q   <= 1'b0;
                        cpu_rdata_q <= mod_we_q ? {DATA_W{1'b0}} : sel_rdata_s;
                        mod_sel_q   <= '0;
                        mod_we_q    <= 1'b0;
`ifdef MM_BUS_TIMEOUT_EN
                    end else if (cnt_q == CNT_W'(TIMEOUT - 32'd1)) begin
                        // Last waiting cycle ends here: this is cycle TIMEOUT of ACCESS.
                        state_q     <= ST_RESP;
                        cpu_ack_q   <= 1'b1;
                        cpu_err_q   <= 1'b1;
                        cpu_rdata_q <= ERR_DATA;
                        err_addr_q  <= addr_q;
                        mod_sel_q   <= '0;
                        mod_we_q    <= 1'b0;
                        cnt_q       <= cnt_q + CNT_W'(1);
`endif
                    end else begin
                        state_q <= ST_ACCESS;
`ifdef MM_BUS_TIMEOUT_EN
                        cnt_q   <= cnt_q + CNT_W'(1);
`endif
                    end
                end

                ST_RESP: begin
                    // The ack lasts one cycle; a held request is re-sampled in IDLE.
                    state_q   <= ST_IDLE;
                    cpu_ack_q <= 1'b0;
                    cpu_err_q <= 1'b0;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    cpu_ack_q <= 1'b0;
                    cpu_err_q <= 1'b0;
                    mod_sel_q <= '0;
                    mod_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.mod_sel   = mod_sel_q;
    assign bus.mod_we    = mod_we_q;
    assign bus.mod_addr  = mod_addr_q;
    assign bus.mod_wdata = mod_wdata_q;
    assign bus.err_addr  = err_addr_q;

endmodule
